// File: rtl/pkt_fifo_sync.sv
// Packet-aware synchronous FIFO: words become readable only once their packet's
// last word is written; a packet can be discarded early with wdrop or by overflow.
module pkt_fifo_sync #(
    parameter int ADDR_WIDTH   = 10,
    parameter int W_EL         = 20,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [W_EL-1:0]       wdata,
    input  logic                  wlast,
    input  logic                  wdrop,
    output logic                  full,
    output logic                  afull,
    input  logic                  ren,
    output logic [W_EL-1:0]       rdata,
    output logic                  rlast,
    output logic                  rvalid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic [15:0]           ovf_count
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AFULL_LVL = PW'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = PW'(1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = PW'(1);
    localparam logic [15:0]         OVF_MAX   = 16'hFFFF;

    // Each entry carries the packet-end marker above the data bits.
    logic [W_EL:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] cptr_q, cptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0] occ_d;
    logic [ADDR_WIDTH:0] pkt_count_q, pkt_count_d;
    logic [15:0]         ovf_count_q, ovf_count_d;
    logic                bad_q, bad_d;
    logic                full_q, full_d;
    logic                afull_q, afull_d;
    logic                empty_q, empty_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;
    logic [W_EL-1:0]     rdata_q, rdata_d;

    logic                wr_acc_s;
    logic                rd_acc_s;
    logic                rd_last_s;
    logic                commit_s;
    logic                ovf_evt_s;
    logic [W_EL:0]       rd_word_s;

    assign rd_word_s = mem[rptr_q[ADDR_WIDTH-1:0]];

    // Next-state computation for pointers, flags, counters and read port.
    always_comb begin
        wr_acc_s    = wen && !full_q && !wdrop;
        rd_acc_s    = ren && !empty_q;
        rd_last_s   = rd_acc_s && rd_word_s[W_EL];
        wptr_d      = wptr_q;
        cptr_d      = cptr_q;
        bad_d       = bad_q;
        commit_s    = 1'b0;
        ovf_evt_s   = 1'b0;

        if (wdrop) begin
            wptr_d = cptr_q;
            bad_d  = 1'b0;
        end else if (wen) begin
            // A last word on a packet that already hit full (or hits it now) drops it.
            if (wlast && (full_q || bad_q)) begin
                wptr_d    = cptr_q;
                bad_d     = 1'b0;
                ovf_evt_s = 1'b1;
            end else if (full_q) begin
                bad_d = 1'b1;
            end else if (wlast) begin
                wptr_d   = wptr_q + PTR_ONE;
                cptr_d   = wptr_q + PTR_ONE;
                commit_s = 1'b1;
            end else begin
                wptr_d = wptr_q + PTR_ONE;
            end
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_acc_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end

        if (ovf_evt_s && (ovf_count_q != OVF_MAX)) begin
            ovf_count_d = ovf_count_q + 16'd1;
        end else begin
            ovf_count_d = ovf_count_q;
        end

        case ({commit_s, rd_last_s})
            2'b10:   pkt_count_d = pkt_count_q + CNT_ONE;
            2'b01:   pkt_count_d = pkt_count_q - CNT_ONE;
            default: pkt_count_d = pkt_count_q;
        endcase

        // Status flags come from the post-edge pointers so they are exact next cycle.
        occ_d   = wptr_d - rptr_d;
        full_d  = (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]) &&
                  (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]);
        empty_d = (rptr_d == cptr_d);
        afull_d = (occ_d >= AFULL_LVL);

        rvalid_d = rd_acc_s;
        rlast_d  = rd_last_s;
        if (rd_acc_s) begin
            rdata_d = rd_word_s[W_EL-1:0];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Storage array write port; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !reset) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= {wlast, wdata};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            cptr_q      <= '0;
            rptr_q      <= '0;
            bad_q       <= 1'b0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            empty_q     <= 1'b1;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
            pkt_count_q <= '0;
            ovf_count_q <= 16'd0;
        end else begin
            wptr_q      <= wptr_d;
            cptr_q      <= cptr_d;
            rptr_q      <= rptr_d;
            bad_q       <= bad_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            empty_q     <= empty_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rdata_q     <= rdata_d;
            pkt_count_q <= pkt_count_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign full      = full_q;
    assign afull     = afull_q;
    assign empty     = empty_q;
    assign rvalid    = rvalid_q;
    assign rlast     = rlast_q;
    assign rdata     = rdata_q;
    assign pkt_count = pkt_count_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_pkt_fifo_sync.sv
// Bench for pkt_fifo_sync (ADDR_WIDTH=4, W_EL=8, AFULL_THRESH=12): a directed
// vector table plus packet-level reference queues checked every cycle.
module tb_pkt_fifo_sync;

    logic       clk = 1'b0;
    logic       reset, wen, wlast, wdrop, ren;
    logic [7:0] wdata;
    logic       full, afull, rlast, rvalid, empty;
    logic [7:0] rdata;
    logic [4:0] pkt_count;
    logic [15:0] ovf_count;

    pkt_fifo_sync #(.ADDR_WIDTH(4), .W_EL(8), .AFULL_THRESH(12)) dut (
        .clk(clk), .reset(reset), .wen(wen), .wdata(wdata), .wlast(wlast),
        .wdrop(wdrop), .full(full), .afull(afull), .ren(ren), .rdata(rdata),
        .rlast(rlast), .rvalid(rvalid), .empty(empty), .pkt_count(pkt_count),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } word_t;

    typedef struct {
        bit         we;
        logic [7:0] wd;
        bit         wl;
        bit         wdr;
        bit         re;
        bit         e_full;
        bit         e_afull;
        bit         e_empty;
        int         e_pkt;
        bit         e_rvalid;
        bit         e_chkd;
        logic [7:0] e_rdata;
        bit         e_rlast;
    } vec_t;

    word_t store[$];
    word_t pend[$];
    word_t expq[$];
    bit         m_bad;
    int         m_ovf;
    logic [7:0] m_rdata;
    bit         m_rdata_known;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_pkts();
        int n = 0;
        foreach (store[i]) begin
            if (store[i].last) n++;
        end
        return n;
    endfunction

    function automatic int model_occ();
        return store.size() + pend.size();
    endfunction

    task automatic check_outputs();
        word_t w;
        chk("full",   32'(full),   32'(model_occ() == 16));
        chk("afull",  32'(afull),  32'(model_occ() >= 12));
        chk("empty",  32'(empty),  32'(store.size() == 0));
        chk("pkt",    32'(pkt_count), 32'(model_pkts()));
        chk("ovf",    32'(ovf_count), 32'(m_ovf));
        if (rvalid) begin
            if (expq.size() == 0) begin
                chk("rvalid_unexpected", 32'(rvalid), 32'd0);
            end else begin
                w = expq.pop_front();
                chk("rdata", 32'(rdata), 32'(w.data));
                chk("rlast", 32'(rlast), 32'(w.last));
                m_rdata = w.data;
                m_rdata_known = 1'b1;
            end
        end else begin
            chk("rvalid_missing", 32'(expq.size()), 32'd0);
            if (m_rdata_known) chk("rdata_hold", 32'(rdata), 32'(m_rdata));
        end
    endtask

    // One clock: drive inputs, advance the reference, then check after the edge.
    task automatic cycle(input bit r, input bit we, input logic [7:0] wd,
                         input bit wl, input bit wdr, input bit re);
        bit mfull, mempty;
        reset = r; wen = we; wdata = wd; wlast = wl; wdrop = wdr; ren = re;
        mfull  = (model_occ() == 16);
        mempty = (store.size() == 0);
        if (r) begin
            store.delete(); pend.delete(); expq.delete();
            m_bad = 1'b0; m_ovf = 0; m_rdata_known = 1'b0;
        end else begin
            if (re && !mempty) expq.push_back(store.pop_front());
            if (wdr) begin
                pend.delete();
                m_bad = 1'b0;
            end else if (we) begin
                if (!mfull) pend.push_back({wl, wd});
                else if (!wl) m_bad = 1'b1;
                if (wl) begin
                    if (mfull || m_bad) begin
                        pend.delete();
                        m_bad = 1'b0;
                        m_ovf++;
                    end else begin
                        foreach (pend[i]) store.push_back(pend[i]);
                        pend.delete();
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    vec_t tbl[16];

    initial begin
        int   sent;
        int   pkt_peak;
        int   k;
        bit   we_r, wl_r, re_r, wdr_r;

        reset = 1'b1; wen = 1'b0; wdata = 8'h00; wlast = 1'b0; wdrop = 1'b0; ren = 1'b0;
        m_bad = 1'b0; m_ovf = 0; m_rdata_known = 1'b0;

        // Basic packet, empty reads, then a dropped partial packet.
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h11, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h22, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, 8'h33, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[9]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[10] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[11] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[12] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[13] = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[14] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h33, 1'b0};

        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_empty",  32'(empty),  32'd1);
        chk("rst_full",   32'(full),   32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast",  32'(rlast),  32'd0);

        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, tbl[i].we, tbl[i].wd, tbl[i].wl, tbl[i].wdr, tbl[i].re);
            chk($sformatf("vec%0d_full", i),   32'(full),      32'(tbl[i].e_full));
            chk($sformatf("vec%0d_afull", i),  32'(afull),     32'(tbl[i].e_afull));
            chk($sformatf("vec%0d_empty", i),  32'(empty),     32'(tbl[i].e_empty));
            chk($sformatf("vec%0d_pkt", i),    32'(pkt_count), 32'(tbl[i].e_pkt));
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid),    32'(tbl[i].e_rvalid));
            if (tbl[i].e_chkd) chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(tbl[i].e_rdata));
            if (tbl[i].e_rvalid) chk($sformatf("vec%0d_rlast", i), 32'(rlast), 32'(tbl[i].e_rlast));
        end
        chk("drop_ovf", 32'(ovf_count), 32'd0);

        // 20-word packet overflows a 16-word store.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 8'(8'h40 + i), (i == 19), 1'b0, 1'b0);
            if (i == 10) chk("afull_at_11", 32'(afull), 32'd0);
            if (i == 11) chk("afull_at_12", 32'(afull), 32'd1);
            if (i == 14) chk("full_at_15",  32'(full),  32'd0);
            if (i == 15) chk("full_at_16",  32'(full),  32'd1);
        end
        chk("ovf_after_20", 32'(ovf_count), 32'd1);
        chk("full_after_rollback",  32'(full),  32'd0);
        chk("empty_after_rollback", 32'(empty), 32'd1);
        chk("afull_after_rollback", 32'(afull), 32'd0);

        // Full committed packet drained while a second packet streams in.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'(8'h80 + i), (i == 15), 1'b0, 1'b0);
        end
        chk("full16_full", 32'(full), 32'd1);
        chk("full16_pkt",  32'(pkt_count), 32'd1);
        sent = 0; pkt_peak = 0; k = 0;
        while (k < 60 && !(sent == 4 && store.size() == 0 && pend.size() == 0 && expq.size() == 0)) begin
            we_r = (k >= 1) && (sent < 4) && (model_occ() < 16);
            cycle(1'b0, we_r, 8'(8'hC0 + sent), we_r && (sent == 3), 1'b0, store.size() != 0);
            if (we_r) sent++;
            if (k == 0) chk("full_after_first_read", 32'(full), 32'd0);
            if (int'(pkt_count) > pkt_peak) pkt_peak = int'(pkt_count);
            k++;
        end
        chk("concurrent_drained", 32'(expq.size() + store.size()), 32'd0);
        chk("pkt_peak", 32'(pkt_peak), 32'd2);
        chk("concurrent_empty", 32'(empty), 32'd1);

        // Reset with two committed packets and one partial pending.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, 8'(8'h60 + i), (i == 1) || (i == 3), 1'b0, 1'b0);
        end
        chk("pre_reset_pkt", 32'(pkt_count), 32'd2);
        cycle(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        chk("mrst_full",   32'(full),      32'd0);
        chk("mrst_afull",  32'(afull),     32'd0);
        chk("mrst_empty",  32'(empty),     32'd1);
        chk("mrst_rvalid", 32'(rvalid),    32'd0);
        chk("mrst_rlast",  32'(rlast),     32'd0);
        chk("mrst_pkt",    32'(pkt_count), 32'd0);
        chk("mrst_ovf",    32'(ovf_count), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("post_rst_ren_rvalid", 32'(rvalid), 32'd0);

        // Random traffic: write-heavy phase to hit full/overflow, then read-heavy.
        for (int i = 0; i < 400; i++) begin
            we_r  = ($urandom_range(3) != 0);
            wl_r  = ($urandom_range(5) == 0);
            wdr_r = ($urandom_range(39) == 0);
            re_r  = (i < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            cycle(1'b0, we_r, 8'($urandom_range(255)), wl_r, wdr_r, re_r);
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        end
        chk("final_empty", 32'(empty), 32'd1);
        chk("final_expq",  32'(expq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
